// File: rtl/channel_err_inj_if.sv
// channel_err_inj_if: symbol channel entering and leaving the error injector.
interface channel_err_inj_if #(parameter int W = 2);
  logic valid_i;
  logic [W-1:0] sym_i;
  logic valid_o;
  logic [W-1:0] sym_o;
  logic err_o;
  modport master (output valid_i, sym_i, input valid_o, sym_o, err_o);
  modport slave (input valid_i, sym_i, output valid_o, sym_o, err_o);
endinterface

// File: rtl/channel_err_inj.sv
// channel_err_inj: LFSR-triggered single/burst/forced bit-flip injection on a symbol channel,
// with a saturating count of inverted bits.
module channel_err_inj #(
  parameter int W = 2,
  parameter int N = 5,
  parameter int BURST_MAX = 4,
  parameter logic [31:0] SEED = 32'hACE12345,
  localparam int BW = $clog2(BURST_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic [1:0] mode_i,
  input  logic [BW-1:0] burst_len_i,
  input  logic [W-1:0] bit_mask_i,
  input  logic clr_cnt_i,
  channel_err_inj_if.slave ch,
  output logic [15:0] err_cnt_o
);
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [31:0] SEED0 = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
  localparam logic [BW-1:0] ONE = BW'(1);
  localparam int PW = $clog2(W + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q;
  logic [BW-1:0] rem_q, len;
  logic [31:0] lfsr_q, lfsr_d;
  logic [W-1:0] flip, sym_q, sym_d;
  logic [PW-1:0] pc;
  logic [16:0] sum;
  logic [15:0] cnt_q, cnt_d;
  logic valid_q, err_q, trig, burst_mode;
  assign trig = ch.valid_i && (&lfsr_q[N-1:0]);
  assign burst_mode = mode_i == 2'b10;
  assign len = burst_len_i == '0 ? ONE : burst_len_i > BMAX ? BMAX : burst_len_i;
  assign flip = ch.valid_i && (mode_i == 2'b11 || (mode_i == 2'b01 && trig) ||
                (burst_mode && (state_q == BURST || trig))) ? bit_mask_i : '0;
  always_comb begin
    pc = '0;
    for (int i = 0; i < W; i++) pc = pc + PW'(flip[i]);
    sum = {1'b0, cnt_q} + 17'(pc);
    cnt_d = clr_cnt_i ? '0 : sum[16] ? 16'hFFFF : sum[15:0];
    lfsr_d = ch.valid_i ? (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0) : lfsr_q;
    sym_d = ch.valid_i ? ch.sym_i ^ flip : sym_q;
  end
  // Triggers seen while in BURST are ignored; gaps (valid_i=0) leave the burst untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      lfsr_q <= SEED0;
      valid_q <= 1'b0;
      sym_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      valid_q <= ch.valid_i;
      sym_q <= sym_d;
      err_q <= |flip;
      cnt_q <= cnt_d;
      if (!burst_mode) begin
        state_q <= IDLE;
        rem_q <= '0;
      end else if (ch.valid_i) begin
        if (state_q == BURST) begin
          rem_q <= rem_q - ONE;
          if (rem_q == ONE) state_q <= IDLE;
        end else if (trig) begin
          rem_q <= len - ONE;
          state_q <= len > ONE ? BURST : IDLE;
        end
      end
    end
  end
  assign ch.valid_o = valid_q;
  assign ch.sym_o = sym_q;
  assign ch.err_o = err_q;
  assign err_cnt_o = cnt_q;
endmodule

// File: tb/tb_channel_err_inj.sv
// tb_channel_err_inj: directed scoreboard bench for channel_err_inj against a behavioural model.
module tb_channel_err_inj;
  localparam int W = 2, N = 5, BMAX = 4, BW = 3;
  localparam logic [31:0] SEED = 32'hACE12345, TAPS = 32'h8020_0003;
  typedef struct packed {logic v; logic [W-1:0] s; logic e; logic [15:0] c;} exp_t;
  logic clk = 1'b0, rst;
  logic [1:0] mode;
  logic [BW-1:0] blen;
  logic [W-1:0] mask, s;
  logic clr;
  logic [15:0] cnt;
  logic [31:0] m_lfsr, x;
  logic [W-1:0] m_sym;
  logic m_burst;
  int m_rem, m_cnt, checks, errors, err_seen, base, ft, k;
  exp_t q[$];
  channel_err_inj_if #(.W(W)) bus ();
  channel_err_inj #(.W(W), .N(N), .BURST_MAX(BMAX), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .mode_i(mode), .burst_len_i(blen), .bit_mask_i(mask),
    .clr_cnt_i(clr), .ch(bus.slave), .err_cnt_o(cnt));
  always #5 clk = ~clk;
  initial begin
    #1_500_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  function automatic logic [31:0] adv(input logic [31:0] v);
    return v[0] ? (v >> 1) ^ TAPS : v >> 1;
  endfunction
  function automatic logic trg(input logic [31:0] v);
    return &v[N-1:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    m_lfsr = SEED; m_burst = 1'b0; m_rem = 0; m_sym = '0; m_cnt = 0;
    q.delete();
  endtask
  task automatic step(input logic v, input logic [W-1:0] sy);
    exp_t e;
    logic [W-1:0] f;
    logic t;
    int l, pc;
    bus.valid_i = v; bus.sym_i = sy;
    t = v && trg(m_lfsr);
    f = '0;
    if (v && (mode == 2'b11 || (mode == 2'b01 && t) || (mode == 2'b10 && (m_burst || t)))) f = mask;
    if (mode != 2'b10) begin
      m_burst = 1'b0; m_rem = 0;
    end else if (v && m_burst) begin
      m_rem--;
      if (m_rem == 0) m_burst = 1'b0;
    end else if (t) begin
      l = int'(blen);
      if (l == 0) l = 1;
      if (l > BMAX) l = BMAX;
      m_rem = l - 1; m_burst = l > 1;
    end
    if (v) begin m_lfsr = adv(m_lfsr); m_sym = sy ^ f; end
    pc = $countones(f);
    m_cnt = clr ? 0 : (m_cnt + pc > 65535 ? 65535 : m_cnt + pc);
    e.v = v; e.s = m_sym; e.e = v && (f != '0); e.c = 16'(m_cnt);
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 0) chk("queue_empty", 1, 0);
    else begin
      e = q.pop_front();
      chk("valid_o", bus.valid_o, e.v);
      chk("sym_o", bus.sym_o, e.s);
      chk("err_o", bus.err_o, e.e);
      chk("err_cnt_o", cnt, e.c);
    end
    if (bus.err_o) err_seen++;
  endtask
  // Idle in mode 00 until the next symbol triggers; want3 selects whether symbol +3 triggers too.
  task automatic seek(input logic want3);
    int n = 0;
    mode = 2'b00;
    while (!(trg(m_lfsr) && trg(adv(adv(adv(m_lfsr)))) == want3) && n < 20000) begin
      step(1'b1, W'($urandom)); n++;
    end
    chk("seek", n < 20000, 1);
  endtask
  initial begin
    checks = 0; errors = 0; err_seen = 0;
    mode = 2'b00; blen = 3; mask = '0; clr = 1'b0; bus.valid_i = 1'b0; bus.sym_i = '0;
    rst = 1'b0;
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_sym", bus.sym_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b1;
    // forced mode
    mode = 2'b11; mask = 2'b10;
    repeat (10) begin
      step(1'b1, 2'b01);
      chk("force_sym", bus.sym_o, 2'b11);
      chk("force_err", bus.err_o, 1);
    end
    chk("force_cnt", cnt, 10);
    step(1'b0, 2'b00);
    chk("hold_sym", bus.sym_o, 2'b11);
    chk("hold_err", bus.err_o, 0);
    // off mode passes symbols through
    mode = 2'b00; mask = 2'b11;
    repeat (6) begin
      s = W'($urandom);
      step(1'b1, s);
      chk("off_sym", bus.sym_o, s);
    end
    // burst of 3, then clean
    seek(1'b0);
    mode = 2'b10; blen = 3; base = m_cnt;
    repeat (3) begin step(1'b1, 2'b00); chk("b3_sym", bus.sym_o, 2'b11); end
    step(1'b1, 2'b00);
    chk("b3_clean", bus.sym_o, 2'b00);
    chk("b3_cnt", cnt, base + 6);
    // clamped length 7->4 with a trigger inside the burst that must be ignored
    seek(1'b1);
    mode = 2'b10; blen = 7; base = m_cnt;
    repeat (4) begin step(1'b1, 2'b00); chk("b4_sym", bus.sym_o, 2'b11); end
    chk("b4_cnt", cnt, base + 8);
    repeat (3) step(1'b1, W'($urandom));
    // gapped burst
    seek(1'b0);
    mode = 2'b10; blen = 3;
    step(1'b1, 2'b00); chk("gap_s0", bus.sym_o, 2'b11);
    step(1'b0, 2'b00); chk("gap_v1", bus.valid_o, 0);
    step(1'b0, 2'b00); chk("gap_s2", bus.sym_o, 2'b11);
    step(1'b1, 2'b00); chk("gap_s3", bus.sym_o, 2'b11);
    step(1'b1, 2'b00); chk("gap_s4", bus.sym_o, 2'b11);
    step(1'b1, 2'b00); chk("gap_end", bus.sym_o, 2'b00);
    // burst length sampled only at start
    seek(1'b0);
    mode = 2'b10; blen = 2;
    step(1'b1, 2'b00);
    blen = 4;
    step(1'b1, 2'b00); chk("len_s1", bus.sym_o, 2'b11);
    step(1'b1, 2'b00); chk("len_end", bus.sym_o, 2'b00);
    // length 0 behaves as 1
    seek(1'b0);
    mode = 2'b10; blen = 0;
    step(1'b1, 2'b00); chk("l0_s0", bus.sym_o, 2'b11);
    step(1'b1, 2'b00); chk("l0_end", bus.sym_o, 2'b00);
    // leaving mode 10 mid-burst drops the burst
    seek(1'b0);
    mode = 2'b10; blen = 4;
    step(1'b1, 2'b00);
    mode = 2'b01;
    step(1'b1, 2'b00); chk("mchg_s1", bus.sym_o, 2'b00);
    mode = 2'b10;
    step(1'b1, 2'b00); chk("mchg_s2", bus.sym_o, 2'b00);
    // zero mask still consumes the burst
    seek(1'b0);
    mode = 2'b10; blen = 2; mask = 2'b00;
    step(1'b1, 2'b00); chk("m0_err", bus.err_o, 0);
    step(1'b1, 2'b00); chk("m0_sym", bus.sym_o, 2'b00);
    mask = 2'b11;
    step(1'b1, 2'b00); chk("m0_after", bus.sym_o, 2'b00);
    // single mode statistics
    mode = 2'b01; mask = 2'b01; err_seen = 0;
    repeat (32768) step(1'b1, W'($urandom));
    chk("rate_lo", err_seen >= 922, 1);
    chk("rate_hi", err_seen <= 1126, 1);
    // saturation and clear priority
    mode = 2'b11; mask = 2'b11;
    repeat (32770) step(1'b1, W'($urandom));
    chk("sat_cnt", cnt, 16'hFFFF);
    clr = 1'b1;
    step(1'b1, 2'b00);
    chk("clr_err", bus.err_o, 1);
    chk("clr_cnt", cnt, 0);
    clr = 1'b0;
    // reset mid-burst
    seek(1'b0);
    mode = 2'b10; blen = 4;
    step(1'b1, 2'b00); step(1'b1, 2'b00);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", bus.valid_o, 0);
    chk("arst_sym", bus.sym_o, 0);
    chk("arst_err", bus.err_o, 0);
    chk("arst_cnt", cnt, 0);
    mreset();
    @(posedge clk); #1;
    rst = 1'b1;
    x = SEED; ft = 0;
    while (!trg(x) && ft < 5000) begin x = adv(x); ft++; end
    mode = 2'b01; mask = 2'b01; k = 0;
    step(1'b1, 2'b00);
    while (!bus.err_o && k < 5000) begin k++; step(1'b1, 2'b00); end
    chk("first_trig", k, ft);
    repeat (200) step(1'b1, W'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
